// File: rtl/level_controller_if.sv
// rtl/level_controller_if.sv - player/game-side bundle for level_controller (LEVEL_BEST_TRACK_EN adds best_level)
interface level_controller_if #(
    parameter int LEVEL_W = 6,
    parameter int SPEED_W = 11,
    parameter int BLK_W   = 4
);
    logic               go;
    logic               next_signal;
    logic [BLK_W-1:0]   miss_count;
    logic [SPEED_W-1:0] speed_count;
    logic [BLK_W-1:0]   num_blocks;
    logic [LEVEL_W-1:0] curr_level;
    logic               level_start;
    logic               game_over;
    logic               game_won;
`ifdef LEVEL_BEST_TRACK_EN
    logic [LEVEL_W-1:0] best_level;
`endif

    modport master (
        output go,
        output next_signal,
        output miss_count,
        input  speed_count,
        input  num_blocks,
        input  curr_level,
        input  level_start,
        input  game_over,
        input  game_won
`ifdef LEVEL_BEST_TRACK_EN
        ,
        input  best_level
`endif
    );

    modport slave (
        input  go,
        input  next_signal,
        input  miss_count,
        output speed_count,
        output num_blocks,
        output curr_level,
        output level_start,
        output game_over,
        output game_won
`ifdef LEVEL_BEST_TRACK_EN
        ,
        output best_level
`endif
    );
endinterface

// File: rtl/level_controller.sv
// rtl/level_controller.sv - level sequencer: speed, row width and win/lose tracking
// Optional LEVEL_BEST_TRACK_EN adds a best_level register that survives game_over.
module level_controller #(
    parameter int NUM_LEVELS = 15,
    parameter int LEVEL_W    = 6,
    parameter int SPEED_W    = 11,
    parameter int BASE_SPEED = 60,
    parameter int SPEED_STEP = 4,
    parameter int MIN_SPEED  = 3,
    parameter int BLK_W      = 4,
    parameter int MAX_BLOCKS = 3,
    parameter int DROP_EVERY = 5
) (
    input  logic               clk,
    input  logic               resetn,
    level_controller_if.slave  bus
);
    typedef enum logic [1:0] {WAIT, ARM, PLAY, WON} state_t;

    localparam int BAND_W = (DROP_EVERY > 1) ? $clog2(DROP_EVERY) : 1;
    localparam logic [BAND_W-1:0]  BAND_LAST  = BAND_W'(DROP_EVERY - 1);
    localparam logic [LEVEL_W-1:0] LEVEL_ONE  = LEVEL_W'(1);
    localparam logic [LEVEL_W-1:0] LEVEL_LAST = LEVEL_W'(NUM_LEVELS);
    localparam logic [SPEED_W-1:0] SPEED_BASE = SPEED_W'(BASE_SPEED);
    localparam logic [SPEED_W-1:0] SPEED_DEC  = SPEED_W'(SPEED_STEP);
    localparam logic [SPEED_W-1:0] SPEED_MIN  = SPEED_W'(MIN_SPEED);
    localparam logic [SPEED_W-1:0] SPEED_KNEE = SPEED_W'(MIN_SPEED + SPEED_STEP);
    localparam logic [BLK_W-1:0]   BLK_MAX    = BLK_W'(MAX_BLOCKS);
    localparam logic [BLK_W-1:0]   BLK_ONE    = BLK_W'(1);

    state_t             state;
    logic [LEVEL_W-1:0] curr_level;
    logic [SPEED_W-1:0] speed_count;
    logic [BLK_W-1:0]   num_blocks;
    logic [BLK_W-1:0]   cap;
    logic [BAND_W-1:0]  band;
    logic               level_start;
    logic               game_over;
    logic               game_won;

    logic [BAND_W-1:0]  band_next;
    logic [BLK_W-1:0]   cap_next;
    logic [BLK_W-1:0]   remaining;
    logic [BLK_W-1:0]   blocks_next;
    logic [SPEED_W-1:0] speed_next;
    logic               lost;

    // Cap drops once per DROP_EVERY levels, tracked by position within the band.
    always_comb begin
        band_next   = band + BAND_W'(1);
        cap_next    = cap;
        if (band == BAND_LAST) begin
            band_next = '0;
            cap_next  = (cap > BLK_ONE) ? cap - BLK_ONE : BLK_ONE;
        end
        remaining   = num_blocks - bus.miss_count;
        blocks_next = (remaining < cap_next) ? remaining : cap_next;
        // Compare before subtracting so speed never wraps below the floor.
        speed_next  = (speed_count > SPEED_KNEE) ? speed_count - SPEED_DEC : SPEED_MIN;
        lost        = (bus.miss_count >= num_blocks);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= WAIT;
            curr_level  <= LEVEL_ONE;
            speed_count <= SPEED_BASE;
            num_blocks  <= BLK_MAX;
            cap         <= BLK_MAX;
            band        <= '0;
            level_start <= 1'b0;
            game_over   <= 1'b0;
            game_won    <= 1'b0;
        end else begin
            level_start <= 1'b0;
            game_over   <= 1'b0;
            case (state)
                WAIT: begin
                    if (bus.go) state <= ARM;
                end
                ARM: begin
                    if (!bus.go) begin
                        state       <= PLAY;
                        level_start <= 1'b1;
                    end
                end
                PLAY: begin
                    if (bus.next_signal) begin
                        if (lost) begin
                            game_over   <= 1'b1;
                            curr_level  <= LEVEL_ONE;
                            speed_count <= SPEED_BASE;
                            num_blocks  <= BLK_MAX;
                            cap         <= BLK_MAX;
                            band        <= '0;
                            state       <= WAIT;
                        end else if (curr_level == LEVEL_LAST) begin
                            game_won <= 1'b1;
                            state    <= WON;
                        end else begin
                            curr_level  <= curr_level + LEVEL_ONE;
                            speed_count <= speed_next;
                            num_blocks  <= blocks_next;
                            cap         <= cap_next;
                            band        <= band_next;
                            state       <= WAIT;
                        end
                    end
                end
                WON: begin
                    if (bus.go) begin
                        game_won    <= 1'b0;
                        curr_level  <= LEVEL_ONE;
                        speed_count <= SPEED_BASE;
                        num_blocks  <= BLK_MAX;
                        cap         <= BLK_MAX;
                        band        <= '0;
                        state       <= ARM;
                    end
                end
                default: state <= WAIT;
            endcase
        end
    end

    assign bus.curr_level  = curr_level;
    assign bus.speed_count = speed_count;
    assign bus.num_blocks  = num_blocks;
    assign bus.level_start = level_start;
    assign bus.game_over   = game_over;
    assign bus.game_won    = game_won;

`ifdef LEVEL_BEST_TRACK_EN
    logic [LEVEL_W-1:0] best_level;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            best_level <= LEVEL_ONE;
        end else if (curr_level > best_level) begin
            best_level <= curr_level;
        end
    end

    assign bus.best_level = best_level;
`endif
endmodule

// File: tb/tb_level_controller.sv
// tb/tb_level_controller.sv - directed checks for level_controller
module tb_level_controller;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   ls_cnt = 0;
    int   go_cnt = 0;

    level_controller_if #(.LEVEL_W(6), .SPEED_W(11), .BLK_W(4)) bus ();

    level_controller dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.level_start === 1'b1) ls_cnt++;
        if (bus.game_over === 1'b1) go_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic play(input int miss);
        bus.go = 1'b1;
        @(negedge clk);
        bus.go = 1'b0;
        @(negedge clk);
        bus.next_signal = 1'b1;
        bus.miss_count  = 4'(miss);
        @(negedge clk);
        bus.next_signal = 1'b0;
        bus.miss_count  = '0;
    endtask

    initial begin
        bus.go = 1'b0;
        bus.next_signal = 1'b0;
        bus.miss_count = '0;
        repeat (2) @(negedge clk);
        check("rst_level", bus.curr_level, 1);
        check("rst_speed", bus.speed_count, 60);
        check("rst_blocks", bus.num_blocks, 3);
        check("rst_start", bus.level_start, 0);
        check("rst_over", bus.game_over, 0);
        check("rst_won", bus.game_won, 0);
`ifdef LEVEL_BEST_TRACK_EN
        check("rst_best", bus.best_level, 1);
`endif
        resetn = 1'b1;
        @(negedge clk);

        // go held three cycles: ARM waits for release
        bus.go = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("arm_hold_start", bus.level_start, 0);
        end
        bus.go = 1'b0;
        @(negedge clk);
        check("start_pulse", bus.level_start, 1);
        check("start_level", bus.curr_level, 1);
        check("start_speed", bus.speed_count, 60);
        check("start_blocks", bus.num_blocks, 3);
        @(negedge clk);
        check("start_once", ls_cnt, 1);

        bus.next_signal = 1'b1;
        @(negedge clk);
        bus.next_signal = 1'b0;
        check("l2_level", bus.curr_level, 2);
        check("l2_speed", bus.speed_count, 56);
        check("l2_blocks", bus.num_blocks, 3);
        // in WAIT, next_signal must not advance
        bus.next_signal = 1'b1;
        @(negedge clk);
        bus.next_signal = 1'b0;
        @(negedge clk);
        check("wait_ignore", bus.curr_level, 2);

        for (int i = 0; i < 3; i++) play(0);
        check("l5_level", bus.curr_level, 5);
        play(0);
        check("l6_level", bus.curr_level, 6);
        check("l6_cap", bus.num_blocks, 2);
        check("l6_speed", bus.speed_count, 40);
        play(1);
        check("l7_level", bus.curr_level, 7);
        check("l7_blocks", bus.num_blocks, 1);
        check("l7_speed", bus.speed_count, 36);

        // abandon level 7 mid-PLAY
        bus.go = 1'b1;
        @(negedge clk);
        bus.go = 1'b0;
        @(negedge clk);
        check("l7_start", bus.level_start, 1);
`ifdef LEVEL_BEST_TRACK_EN
        check("best_7", bus.best_level, 7);
`endif
        #2 resetn = 1'b0;
        #1;
        check("midrst_level", bus.curr_level, 1);
        check("midrst_speed", bus.speed_count, 60);
        check("midrst_blocks", bus.num_blocks, 3);
        check("midrst_start", bus.level_start, 0);
        check("midrst_over", bus.game_over, 0);
`ifdef LEVEL_BEST_TRACK_EN
        check("midrst_best", bus.best_level, 1);
`endif
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("midrst_no_over", go_cnt, 0);

        play(2);
        check("m2_blocks", bus.num_blocks, 1);
        check("m2_level", bus.curr_level, 2);
        play(1);
        check("lose_pulse", bus.game_over, 1);
        check("lose_level", bus.curr_level, 1);
        check("lose_speed", bus.speed_count, 60);
        check("lose_blocks", bus.num_blocks, 3);
        @(negedge clk);
        check("lose_once", go_cnt, 1);
        check("lose_pulse_end", bus.game_over, 0);
`ifdef LEVEL_BEST_TRACK_EN
        check("lose_best_kept", bus.best_level, 2);
`endif

        for (int i = 0; i < 14; i++) play(0);
        check("l15_level", bus.curr_level, 15);
        check("l15_speed", bus.speed_count, 4);
        check("l15_blocks", bus.num_blocks, 1);
        play(0);
        check("won_flag", bus.game_won, 1);
        check("won_level", bus.curr_level, 15);
        check("won_speed", bus.speed_count, 4);
        check("won_blocks", bus.num_blocks, 1);
`ifdef LEVEL_BEST_TRACK_EN
        check("won_best", bus.best_level, 15);
`endif
        bus.next_signal = 1'b1;
        bus.miss_count  = 4'd5;
        @(negedge clk);
        bus.next_signal = 1'b0;
        bus.miss_count  = '0;
        @(negedge clk);
        check("won_ignore_flag", bus.game_won, 1);
        check("won_ignore_level", bus.curr_level, 15);
        check("won_ignore_over", go_cnt, 1);

        bus.go = 1'b1;
        @(negedge clk);
        check("restart_level", bus.curr_level, 1);
        check("restart_speed", bus.speed_count, 60);
        check("restart_blocks", bus.num_blocks, 3);
        check("restart_won", bus.game_won, 0);
        bus.go = 1'b0;
        @(negedge clk);
        check("restart_start", bus.level_start, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/level_controller.md
LEVEL_CONTROLLER -- requirements
Module: level_controller

Interface
REQ-001 The block SHALL have parameter NUM_LEVELS, default 15, meaning number of playable levels (2..63).
REQ-002 The block SHALL have parameter LEVEL_W, default 6, meaning curr_level width.
REQ-003 The block SHALL have parameter SPEED_W, default 11, meaning speed_count width.
REQ-004 The block SHALL have parameter BASE_SPEED, default 60, meaning frames per step at level 1.
REQ-005 The block SHALL have parameter SPEED_STEP, default 4, meaning speed_count decrement per level.
REQ-006 The block SHALL have parameter MIN_SPEED, default 3, meaning speed_count floor.
REQ-007 The block SHALL have parameter BLK_W, default 4, meaning num_blocks and miss_count width.
REQ-008 The block SHALL have parameter MAX_BLOCKS, default 3, meaning block cap at level 1.
REQ-009 The block SHALL have parameter DROP_EVERY, default 5, meaning the block cap falls by 1 every DROP_EVERY levels, floor 1.
REQ-010 The block SHALL have port clk, input, 1 bit, meaning the single clock: one clock; reset is asynchronous and active-low.
REQ-011 The block SHALL have port resetn, input, 1 bit, meaning asynchronous active-low reset.
REQ-012 The block SHALL have port go, input, 1 bit, meaning player button, level-sensitive, synchronous to clk.
REQ-013 The block SHALL have port next_signal, input, 1 bit, meaning one-cycle pulse: row placed.
REQ-014 The block SHALL have port miss_count, input, BLK_W bits, meaning overhanging blocks, valid only with next_signal.
REQ-015 The block SHALL have port speed_count, output, SPEED_W bits, meaning frames per move step.
REQ-016 The block SHALL have port num_blocks, output, BLK_W bits, meaning row width in blocks.
REQ-017 The block SHALL have port curr_level, output, LEVEL_W bits, meaning current level (1-based).
REQ-018 The block SHALL have port level_start, output, 1 bit, meaning one-cycle pulse on entry to PLAY.
REQ-019 The block SHALL have port game_over, output, 1 bit, meaning one-cycle pulse on a lost game.
REQ-020 The block SHALL have port game_won, output, 1 bit, meaning level-high while in state WON.

Function
REQ-021 The FSM SHALL have states WAIT, ARM, PLAY, WON; all outputs SHALL be registered.
REQ-022 WAIT SHALL go to ARM when go=1; ARM SHALL go to PLAY when go=0, so one press starts exactly one level.
REQ-023 level_start SHALL pulse 1 in the first cycle PLAY is held.
REQ-024 In PLAY, next_signal SHALL be sampled; next_signal in WAIT, ARM or WON SHALL be ignored; go SHALL be ignored in PLAY.
REQ-025 In PLAY with next_signal and miss_count >= num_blocks, the block SHALL pulse game_over next cycle, load level 1 values, and enter WAIT.
REQ-026 In PLAY with next_signal, miss_count < num_blocks and curr_level == NUM_LEVELS, the block SHALL enter WON with outputs held.
REQ-027 Otherwise the block SHALL increment curr_level by 1 and enter WAIT.
REQ-028 On that increment, num_blocks SHALL become min(num_blocks - miss_count, cap(new level)).
REQ-029 cap(L) SHALL be max(MAX_BLOCKS - floor((L-1)/DROP_EVERY), 1), kept by an internal level-within-band counter; no divider.
REQ-030 On that increment, speed_count SHALL become max(BASE_SPEED - (L-1)*SPEED_STEP, MIN_SPEED), computed without unsigned underflow.
REQ-031 All updates SHALL occur on the clock edge after next_signal: 1-cycle latency.
REQ-032 WON SHALL go to ARM on go=1 with level 1 values loaded.

Reset
REQ-033 While resetn=0, the block SHALL asynchronously hold state WAIT, curr_level=1, speed_count=BASE_SPEED, num_blocks=MAX_BLOCKS, and level_start, game_over, game_won = 0.
REQ-034 Reset asserted mid-PLAY SHALL abandon the level with no game_over pulse.

Configuration
REQ-035 With macro LEVEL_BEST_TRACK_EN defined, the block SHALL add output best_level (LEVEL_W bits), reset to 1, updated to curr_level whenever curr_level exceeds it, and not cleared by game_over.
REQ-036 Without LEVEL_BEST_TRACK_EN, the block SHALL have no best_level port and no associated logic.

Verification
REQ-037 Bench SHALL check: reset release then go high 3 cycles, then low -> ARM held while go=1, exactly one level_start, curr_level=1, speed_count=60, num_blocks=3.
REQ-038 Bench SHALL check: in PLAY at level 1, next_signal with miss_count=0 -> next cycle curr_level=2, speed_count=56, num_blocks=3, state WAIT.
REQ-039 Bench SHALL check: level 5 to 6 with miss_count=0 -> num_blocks=2 (cap); level 6 with miss_count=1 -> num_blocks=1.
REQ-040 Bench SHALL check: num_blocks=1, next_signal with miss_count=1 -> one game_over pulse, curr_level=1, speed_count=60, num_blocks=3.
REQ-041 Bench SHALL check: a win at level 15 -> game_won=1, speed_count=4; then next_signal is ignored; then go -> level 1 and ARM.
REQ-042 Bench SHALL check: resetn low mid-PLAY at level 7 -> immediate reset values with no game_over; with LEVEL_BEST_TRACK_EN, best_level resets to 1.
